// File: rtl/ir_transmitter.sv
// ir_transmitter: 12-bit pulse-width IR frame generator with envelope and carrier outputs
module ir_transmitter #(
  parameter int BASE_PULSE_WIDTH = 30000,
  parameter int GAP_UNITS = 8,
  parameter int CARRIER_DIV = 1250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_done,
  output logic        ir_out,
  output logic        ir_led
);
  localparam int MAXU = GAP_UNITS > 4 ? GAP_UNITS : 4;
  localparam int CW = $clog2(MAXU * BASE_PULSE_WIDTH);
  localparam int KW = $clog2(CARRIER_DIV);
  typedef enum logic [2:0] {IDLE, START, SPACE, MARK, GAP} state_t;
  state_t state;
  logic [CW-1:0] cnt, dur;
  logic [11:0] sh;
  logic [3:0] bit_cnt;
  logic [KW-1:0] ccnt;
  logic last;
  always_comb begin
    dur = state == START ? CW'(4 * BASE_PULSE_WIDTH) :
          state == MARK  ? (sh[0] ? CW'(2 * BASE_PULSE_WIDTH) : CW'(BASE_PULSE_WIDTH)) :
          state == GAP   ? CW'(GAP_UNITS * BASE_PULSE_WIDTH) : CW'(BASE_PULSE_WIDTH);
    last = cnt == dur - CW'(1);
  end
  // ccnt holds the carrier phase of the next cycle; every low segment (start and bit marks) is modulated
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      bit_cnt <= '0;
      ccnt <= '0;
      ir_out <= 1'b1;
      ir_led <= 1'b0;
      tx_done <= 1'b0;
      tx_ready <= 1'b0;
    end else begin
      tx_done <= state == GAP && cnt == dur - CW'(2);
      cnt <= (state == IDLE || last) ? '0 : cnt + CW'(1);
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            state <= START;
            sh <= tx_data;
            bit_cnt <= '0;
            tx_ready <= 1'b0;
            ir_out <= 1'b0;
            ir_led <= 1'b1;
            ccnt <= KW'(1);
          end else tx_ready <= 1'b1;
        end
        START, MARK: begin
          if (last) begin
            state <= (state == MARK && bit_cnt == 4'd11) ? GAP : SPACE;
            ir_out <= 1'b1;
            ir_led <= 1'b0;
            if (state == MARK) begin
              sh <= sh >> 1;
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            ir_led <= ccnt < KW'(CARRIER_DIV / 2);
            ccnt <= ccnt == KW'(CARRIER_DIV - 1) ? '0 : ccnt + KW'(1);
          end
        end
        SPACE: begin
          if (last) begin
            state <= MARK;
            ir_out <= 1'b0;
            ir_led <= 1'b1;
            ccnt <= KW'(1);
          end
        end
        GAP: begin
          if (last) begin
            state <= IDLE;
            tx_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ir_transmitter.sv
// tb_ir_transmitter: directed frame, carrier, handshake and reset checks for ir_transmitter
module tb_ir_transmitter;
  logic clk = 0;
  logic rst_n = 0;
  logic [11:0] tx_data = '0;
  logic tx_valid = 0;
  logic tx_ready, tx_done, ir_out, ir_led;
  int checks = 0;
  int failures = 0;
  int segs[$];
  int last_gap;

  ir_transmitter #(.BASE_PULSE_WIDTH(10), .GAP_UNITS(8), .CARRIER_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .ir_out(ir_out), .ir_led(ir_led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Sends one word and measures its waveform; called at a negedge with tx_ready high
  task automatic send(input logic [11:0] d, input bit hold, input logic [11:0] nxt,
                      input bit noise, input int exp_len);
    int run, pos, len, bad, led_bad, e;
    bit cur, done;
    check("rdy_before", int'(tx_ready), 1);
    tx_data = d;
    tx_valid = 1;
    @(negedge clk);
    tx_valid = hold;
    if (hold) tx_data = nxt;
    check("latency", int'(ir_out), 0);
    segs.delete();
    run = 0; pos = 0; len = 0; led_bad = 0; cur = 0; done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      if (noise) begin
        tx_valid = (i % 37) == 3;
        tx_data = ~d;
      end
      if (ir_out != cur) begin
        segs.push_back(run);
        cur = ir_out;
        run = 0;
        pos = 0;
      end
      run++;
      len++;
      if (ir_out) led_bad += int'(ir_led);
      else begin
        led_bad += int'(ir_led != ((pos % 4) < 2));
        pos++;
      end
      if (tx_done) done = 1;
      else @(negedge clk);
    end
    segs.push_back(run);
    if (!hold) tx_valid = 0;
    check("done_seen", int'(done), 1);
    check("frame_len", len, exp_len);
    check("carrier", led_bad, 0);
    check("nsegs", segs.size(), 26);
    bad = 0;
    if (segs.size() == 26)
      for (int i = 0; i < 26; i++) begin
        e = i == 0 ? 40 : i == 25 ? 80 : (i % 2) ? 10 : (d[(i - 2) / 2] ? 20 : 10);
        bad += int'(segs[i] != e);
      end
    check("seg_widths", bad, 0);
    last_gap = run;
    @(negedge clk);
    check("rdy_after", int'(tx_ready), 1);
    check("done_pulse", int'(tx_done), 0);
    check("idle_high", int'(ir_out), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ir_out", int'(ir_out), 1);
    check("rst_ir_led", int'(ir_led), 0);
    check("rst_done", int'(tx_done), 0);
    check("rst_ready", int'(tx_ready), 0);
    rst_n = 1;
    @(negedge clk);
    check("ready_after_rst", int'(tx_ready), 1);

    send(12'hF0D, 0, 12'h000, 0, 430);
    send(12'hF0D, 0, 12'h000, 1, 430);
    send(12'hFFF, 0, 12'h000, 0, 480);
    send(12'hF0D, 1, 12'h000, 0, 430);
    check("b2b_gap", last_gap + int'(ir_out), 81);
    send(12'h000, 0, 12'h000, 0, 360);
    send(12'h001, 0, 12'h000, 0, 370);

    tx_data = 12'hFFF;
    tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
    repeat (204) @(negedge clk);
    check("mid_in_mark", int'(ir_out), 0);
    rst_n = 0;
    @(negedge clk);
    check("abort_ir_out", int'(ir_out), 1);
    check("abort_ir_led", int'(ir_led), 0);
    check("abort_done", int'(tx_done), 0);
    check("abort_ready", int'(tx_ready), 0);
    rst_n = 1;
    @(negedge clk);
    check("abort_ready_rel", int'(tx_ready), 1);
    check("abort_done_rel", int'(tx_done), 0);
    send(12'h123, 0, 12'h000, 0, 400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
